digit_serializer_163: RTL

//  Transmit side of the digit interface into the GF(2^163) digit-serial multiplier.
//  - Accepts one 163-bit field element (operand B) through a valid/ready handshake.
//  - Emits it as ceil(M/D) D-bit digits, MSB-first, for the systolic array.
//  - Sits between the operand register file and the array's per-stage digit registers.
//  - Digit stream has its own valid/ready/last handshake, so the array can stall it.

---
 rtl/gf163_pkg.sv | 21 ++
 rtl/digit_shreg.sv | 31 +++
 rtl/digit_serializer_163.sv | 112 +++++++++++
 3 files changed

// File: rtl/gf163_pkg.sv
// Shared constants, state encoding and padding helper for the GF(2^163)
// digit-serial datapath.
package gf163_pkg;

  localparam int M    = 163;
  localparam int D    = 16;
  localparam int NDIG = (M + D - 1) / D;
  localparam int CW   = $clog2(NDIG);
  localparam int PW   = NDIG * D;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Zero-extend an operand to a whole number of digits.
  function automatic logic [PW-1:0] pad_op(input logic [M-1:0] op);
    return {{(PW - M){1'b0}}, op};
  endfunction

endpackage

// File: rtl/digit_shreg.sv
// Parallel-load shift register that presents its top digit and steps left
// by one digit per shift.
module digit_shreg
  import gf163_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic          shift,
  input  logic [PW-1:0] din,
  output logic [D-1:0]  dtop
);

  logic [PW-1:0] sh_r;

  // Load has priority over shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_r <= '0;
    end else if (load) begin
      sh_r <= din;
    end else if (shift) begin
      sh_r <= {sh_r[PW-D-1:0], {D{1'b0}}};
    end else begin
      sh_r <= sh_r;
    end
  end

  assign dtop = sh_r[PW-1 -: D];

endmodule

// File: rtl/digit_serializer_163.sv
// Serializes one 163-bit operand into MSB-first 16-bit digits with a
// stallable valid/ready/last stream and back-to-back operand reload.
module digit_serializer_163
  import gf163_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          abort,
  input  logic [M-1:0]  op_in,
  input  logic          op_valid,
  output logic          op_ready,
  output logic [D-1:0]  dig_out,
  output logic          dig_valid,
  input  logic          dig_ready,
  output logic          dig_last,
  output logic [CW-1:0] dig_idx
);

  state_t        state_r;
  state_t        state_nxt;
  logic [CW-1:0] idx_r;
  logic [CW-1:0] idx_nxt;
  logic          load_s;
  logic          shift_s;
  logic [PW-1:0] din_s;
  logic          xfer_s;
  logic          last_s;
  logic          take_s;

  assign dig_valid = (state_r == SEND);
  assign last_s    = (idx_r == '0);
  assign xfer_s    = dig_valid & dig_ready;
  assign op_ready  = ~abort & ((state_r == IDLE) | (xfer_s & last_s));
  assign take_s    = op_valid & op_ready;
  assign dig_last  = dig_valid & last_s;
  assign dig_idx   = idx_r;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every handshake.
  always_comb begin
    state_nxt = state_r;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (take_s) state_nxt = SEND;
          else        state_nxt = IDLE;
        end
        SEND: begin
          if (xfer_s && last_s && !take_s) state_nxt = IDLE;
          else                             state_nxt = SEND;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath controls; the shift register is zeroed whenever the stream goes idle.
  always_comb begin
    load_s  = 1'b0;
    shift_s = 1'b0;
    din_s   = pad_op(op_in);
    idx_nxt = idx_r;
    if (abort) begin
      load_s  = 1'b1;
      din_s   = '0;
      idx_nxt = '0;
    end else if (take_s) begin
      load_s  = 1'b1;
      idx_nxt = CW'(NDIG - 1);
    end else if (xfer_s) begin
      if (!last_s) begin
        shift_s = 1'b1;
        idx_nxt = idx_r - CW'(1);
      end else begin
        load_s  = 1'b1;
        din_s   = '0;
        idx_nxt = '0;
      end
    end else begin
      idx_nxt = idx_r;
    end
  end

  // Digit index counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_r <= '0;
    end else begin
      idx_r <= idx_nxt;
    end
  end

  digit_shreg u_shreg (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load_s),
    .shift (shift_s),
    .din   (din_s),
    .dtop  (dig_out)
  );

endmodule
